// File: rtl/hex_view_pkg.sv
// hex_view_pkg: shared types, font and colours
// for the hex memory viewer.
package hex_view_pkg;

  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 16;

  typedef logic [GLYPH_W-1:0] glyph_row_t;

  localparam logic [7:0] RGB_BLACK = 8'h00;
  localparam logic [7:0] RGB_WHITE = 8'hFF;
  localparam logic [7:0] RGB_RED   = 8'hE0;

  // 8x8 base font, top row in the high byte,
  // drawn doubled to fill a 16x16 cell.
  localparam logic [63:0] FONT8 [16] = '{
    64'h3C666E7666663C00,
    64'h1838181818187E00,
    64'h3C66060C30607E00,
    64'h3C66061C06663C00,
    64'h0C1C3C6C7E0C0C00,
    64'h7E607C0606663C00,
    64'h3C607C6666663C00,
    64'h7E060C1830303000,
    64'h3C66663C66663C00,
    64'h3C66663E060C3800,
    64'h183C66667E666600,
    64'h7C66667C66667C00,
    64'h3C66606060663C00,
    64'h786C6666666C7800,
    64'h7E60607C60607E00,
    64'h7E60607C60606000
  };

  typedef struct packed {
    logic       draw;
    logic       hl;
    logic [4:0] nib;
    logic [3:0] gcol;
    logic [3:0] grow;
  } cell_t;

  function automatic glyph_row_t expand_row(
    input logic [3:0] nib,
    input logic [3:0] r
  );
    logic [7:0] b;
    glyph_row_t o;
    int         sh;
    sh = 8 * (7 - int'(r >> 1));
    b  = FONT8[nib][sh +: 8];
    o  = '0;
    for (int i = 0; i < 8; i++) begin
      o[2*i]   = b[i];
      o[2*i+1] = b[i];
    end
    return o;
  endfunction

endpackage

// File: rtl/hex_memory_view_glyph_rom.sv
// hex_glyph_rom: combinational glyph lookup,
// one pixel of one hex digit.
module hex_glyph_rom
  import hex_view_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic [3:0] glyph_row,
  input  logic [3:0] glyph_col,
  output logic       glyph_bit
);

  glyph_row_t row_bits;

  // pick the font row, then the column bit
  always_comb begin
    row_bits  = expand_row(nibble, glyph_row);
    glyph_bit = row_bits[4'(GLYPH_W-1) - glyph_col];
  end

endmodule

// File: rtl/hex_memory_view.sv
// hex_memory_view: grid of RAM words drawn as hex
// digits, fixed 3-clk pixel pipeline.
module hex_memory_view
  import hex_view_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINES          = 24,
  parameter int HEX_START_X    = 256,
  parameter int HEX_START_Y    = 0,
  parameter int DIGIT_W        = 16,
  parameter int DIGIT_H        = 16,
  parameter int GAP_W          = 16,
  parameter int BLINK_FRAMES   = 16,
  parameter logic [7:0] DIGIT_COLOR     = RGB_WHITE,
  parameter logic [7:0] HIGHLIGHT_COLOR = RGB_RED
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  start_of_frame,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  highlight_en,
  input  logic [ADDR_WIDTH-1:0] highlight_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  drawing_request,
  output logic [7:0]            rgb
);

  localparam int DIGITS   = DATA_WIDTH / 4;
  localparam int CELL_W   = DIGITS * DIGIT_W;
  localparam int PITCH    = CELL_W + GAP_W;
  localparam int REGION_W = WORDS_PER_LINE * PITCH - GAP_W;
  localparam int REGION_H = LINES * DIGIT_H;
  localparam int FC_W     =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  if ((DATA_WIDTH % 4) != 0 || DIGITS < 1 || DIGITS > 32)
  begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 4, 4..128");
  end

  logic [31:0]           rx, ry;
  logic [31:0]           col, in_p, row;
  logic                  in_x, in_y;
  logic [ADDR_WIDTH-1:0] word_addr;
  cell_t                 c0, s1, s2;
  logic [FC_W-1:0]       frame_cnt;
  logic                  blink_phase;
  logic [31:0]           nib_shift;
  logic [3:0]            nib_val;
  logic                  gbit;

  // decode pixel position into cell fields
  always_comb begin
    rx   = 32'(pixel_x) - 32'(HEX_START_X);
    ry   = 32'(pixel_y) - 32'(HEX_START_Y);
    in_x = (32'(pixel_x) >= 32'(HEX_START_X))
        && (rx < 32'(REGION_W));
    in_y = (32'(pixel_y) >= 32'(HEX_START_Y))
        && (ry < 32'(REGION_H));
    col  = rx / 32'(PITCH);
    in_p = rx % 32'(PITCH);
    row  = ry / 32'(DIGIT_H);
    word_addr = base_addr
      + ADDR_WIDTH'(row * 32'(WORDS_PER_LINE) + col);
    c0      = '0;
    c0.draw = in_x && in_y && (in_p < 32'(CELL_W));
    c0.hl   = c0.draw && highlight_en && blink_phase
           && (word_addr == highlight_addr);
    c0.nib  = 5'(in_p / 32'(DIGIT_W));
    c0.gcol = 4'((in_p % 32'(DIGIT_W))
      * 32'(GLYPH_W) / 32'(DIGIT_W));
    c0.grow = 4'((ry % 32'(DIGIT_H))
      * 32'(GLYPH_H) / 32'(DIGIT_H));
  end

  // stages 1 and 2: fields ride along the RAM read
  always_ff @(posedge clk) begin
    if (!resetN) begin
      s1       <= '0;
      s2       <= '0;
      mem_addr <= '0;
    end else begin
      s1       <= c0;
      s2       <= s1;
      mem_addr <= word_addr;
    end
  end

  // pick the displayed nibble, MSB nibble first
  always_comb begin
    nib_shift = (32'(DIGITS) - 32'd1 - 32'(s2.nib)) << 2;
    nib_val   = 4'(mem_rdata >> nib_shift);
  end

  hex_glyph_rom u_rom (
    .nibble    (nib_val),
    .glyph_row (s2.grow),
    .glyph_col (s2.gcol),
    .glyph_bit (gbit)
  );

  // stage 3: colour the pixel
  always_ff @(posedge clk) begin
    if (!resetN) begin
      drawing_request <= 1'b0;
      rgb             <= 8'h00;
    end else if (!s2.draw) begin
      drawing_request <= 1'b0;
      rgb             <= 8'h00;
    end else if (s2.hl) begin
      drawing_request <= 1'b1;
      rgb             <= gbit ? RGB_BLACK : HIGHLIGHT_COLOR;
    end else begin
      drawing_request <= gbit;
      rgb             <= gbit ? DIGIT_COLOR : 8'h00;
    end
  end

  // blink phase flips every BLINK_FRAMES frames
  always_ff @(posedge clk) begin
    if (!resetN) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (start_of_frame) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hex_memory_view.sv
// tb_hex_memory_view: directed checks of the hex
// viewer, 16-bit and 32-bit word instances.
module tb_hex_memory_view;

  logic        clk = 1'b0;
  logic        resetN;
  logic [9:0]  pixel_x, pixel_y;
  logic        sof;
  logic [7:0]  base_addr;
  logic        hl_en;
  logic [7:0]  hl_addr;
  logic [7:0]  mem_addr, mem_addr32;
  logic [15:0] rdata;
  logic [31:0] rdata32;
  logic        dr, dr32;
  logic [7:0]  rgb, rgb32;
  logic [15:0] ram   [256];
  logic [31:0] ram32 [256];
  int          total, bad;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata   <= ram[mem_addr];
    rdata32 <= ram32[mem_addr32];
  end

  hex_memory_view dut (
    .clk(clk), .resetN(resetN),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .start_of_frame(sof), .base_addr(base_addr),
    .highlight_en(hl_en), .highlight_addr(hl_addr),
    .mem_addr(mem_addr), .mem_rdata(rdata),
    .drawing_request(dr), .rgb(rgb)
  );

  hex_memory_view #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .resetN(resetN),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .start_of_frame(sof), .base_addr(base_addr),
    .highlight_en(hl_en), .highlight_addr(hl_addr),
    .mem_addr(mem_addr32), .mem_rdata(rdata32),
    .drawing_request(dr32), .rgb(rgb32)
  );

  task automatic drive(input int x, input int y);
    @(negedge clk);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
  endtask

  task automatic show(input int x, input int y);
    drive(x, y);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_sof(input int n);
    repeat (n) begin
      @(negedge clk);
      sof = 1'b1;
      @(negedge clk);
      sof = 1'b0;
    end
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pixel_x = 10'(256 + i * 6);
      pixel_y = 10'd0;
      sof = (i == 2);
      @(posedge clk);
      #1;
      total++;
      if (dr !== 1'b0 || rgb !== 8'h00 || mem_addr !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold[%0d]: dr=%b rgb=%h addr=%h want 0 00 00",
                 i, dr, rgb, mem_addr);
      end
    end
    @(negedge clk);
    sof = 1'b0;
    resetN = 1'b1;
    pixel_x = 10'd262;
    pixel_y = 10'd0;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (dr !== 1'b0 || rgb !== 8'h00) begin
        bad++;
        $display("FAIL reset_release[%0d]: dr=%b rgb=%h want 0 00",
                 c, dr, rgb);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (dr !== 1'b1 || rgb !== 8'hFF) begin
      bad++;
      $display("FAIL reset_first_pixel: dr=%b rgb=%h want 1 ff", dr, rgb);
    end
  endtask

  task automatic test_basic_fetch;
    drive(256, 0);
    @(posedge clk);
    #1;
    total++;
    if (mem_addr !== 8'h10) begin
      bad++;
      $display("FAIL fetch_addr: addr=%h want 10", mem_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dr !== 1'b0 || rgb !== 8'h00) begin
      bad++;
      $display("FAIL fetch_A_c0: dr=%b rgb=%h want 0 00", dr, rgb);
    end
    show(262, 0);
    total++;
    if (dr !== 1'b1 || rgb !== 8'hFF) begin
      bad++;
      $display("FAIL fetch_A_c6: dr=%b rgb=%h want 1 ff", dr, rgb);
    end
    show(260, 0);
    total++;
    if (dr !== 1'b0 || rgb !== 8'h00) begin
      bad++;
      $display("FAIL fetch_A_c4: dr=%b rgb=%h want 0 00", dr, rgb);
    end
    show(276, 0);
    total++;
    if (dr !== 1'b1 || rgb !== 8'hFF) begin
      bad++;
      $display("FAIL fetch_3_c4: dr=%b rgb=%h want 1 ff", dr, rgb);
    end
    show(272, 0);
    total++;
    if (dr !== 1'b0 || rgb !== 8'h00) begin
      bad++;
      $display("FAIL fetch_3_c0: dr=%b rgb=%h want 0 00", dr, rgb);
    end
  endtask

  task automatic test_addressing;
    drive(370, 38);
    @(posedge clk);
    #1;
    total++;
    if (mem_addr !== 8'h19) begin
      bad++;
      $display("FAIL addr_r2c1: addr=%h want 19", mem_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dr !== 1'b1 || rgb !== 8'hFF) begin
      bad++;
      $display("FAIL addr_C_c2: dr=%b rgb=%h want 1 ff", dr, rgb);
    end
    show(378, 38);
    total++;
    if (dr !== 1'b0 || rgb !== 8'h00) begin
      bad++;
      $display("FAIL addr_C_c10: dr=%b rgb=%h want 0 00", dr, rgb);
    end
  endtask

  task automatic test_gap_outside;
    int xs [4];
    int ys [4];
    xs = '{255, 262, 560, 262};
    ys = '{0, 384, 0, 1000};
    ram[8'h10] = 16'hFFFF;
    for (int x = 320; x < 336; x++) begin
      show(x, 0);
      total++;
      if (dr !== 1'b0 || rgb !== 8'h00) begin
        bad++;
        $display("FAIL gap x=%0d: dr=%b rgb=%h want 0 00", x, dr, rgb);
      end
    end
    for (int i = 0; i < 4; i++) begin
      show(xs[i], ys[i]);
      total++;
      if (dr !== 1'b0 || rgb !== 8'h00) begin
        bad++;
        $display("FAIL outside (%0d,%0d): dr=%b rgb=%h want 0 00",
                 xs[i], ys[i], dr, rgb);
      end
    end
    ram[8'h10] = 16'hA3C5;
  endtask

  task automatic test_highlight;
    hl_en = 1'b1;
    hl_addr = 8'h10;
    pulse_sof(15);
    show(256, 0);
    total++;
    if (dr !== 1'b0 || rgb !== 8'h00) begin
      bad++;
      $display("FAIL hl_15: dr=%b rgb=%h want 0 00", dr, rgb);
    end
    pulse_sof(1);
    show(256, 0);
    total++;
    if (dr !== 1'b1 || rgb !== 8'hE0) begin
      bad++;
      $display("FAIL hl_bg: dr=%b rgb=%h want 1 e0", dr, rgb);
    end
    show(262, 0);
    total++;
    if (dr !== 1'b1 || rgb !== 8'h00) begin
      bad++;
      $display("FAIL hl_fg: dr=%b rgb=%h want 1 00", dr, rgb);
    end
    show(320, 0);
    total++;
    if (dr !== 1'b0 || rgb !== 8'h00) begin
      bad++;
      $display("FAIL hl_gap: dr=%b rgb=%h want 0 00", dr, rgb);
    end
    show(342, 0);
    total++;
    if (dr !== 1'b1 || rgb !== 8'hFF) begin
      bad++;
      $display("FAIL hl_other_fg: dr=%b rgb=%h want 1 ff", dr, rgb);
    end
    show(336, 0);
    total++;
    if (dr !== 1'b0 || rgb !== 8'h00) begin
      bad++;
      $display("FAIL hl_other_bg: dr=%b rgb=%h want 0 00", dr, rgb);
    end
    hl_en = 1'b0;
    show(256, 0);
    total++;
    if (dr !== 1'b0 || rgb !== 8'h00) begin
      bad++;
      $display("FAIL hl_disabled: dr=%b rgb=%h want 0 00", dr, rgb);
    end
    hl_en = 1'b1;
    pulse_sof(16);
    show(262, 0);
    total++;
    if (dr !== 1'b1 || rgb !== 8'hFF) begin
      bad++;
      $display("FAIL hl_off_fg: dr=%b rgb=%h want 1 ff", dr, rgb);
    end
    show(256, 0);
    total++;
    if (dr !== 1'b0 || rgb !== 8'h00) begin
      bad++;
      $display("FAIL hl_off_bg: dr=%b rgb=%h want 0 00", dr, rgb);
    end
    hl_en = 1'b0;
  endtask

  task automatic test_wrap;
    base_addr = 8'hFE;
    drive(496, 0);
    @(posedge clk);
    #1;
    total++;
    if (mem_addr !== 8'h01) begin
      bad++;
      $display("FAIL wrap16: addr=%h want 01", mem_addr);
    end
    total++;
    if (mem_addr32 !== 8'hFF) begin
      bad++;
      $display("FAIL wrap32: addr=%h want ff", mem_addr32);
    end
    repeat (2) @(posedge clk);
    base_addr = 8'h00;
  endtask

  task automatic test_width32;
    logic [7:0] row3 [8];
    logic [7:0] rb;
    logic       exp;
    row3 = '{8'h18, 8'h0C, 8'h1C, 8'h6C,
             8'h06, 8'h66, 8'h18, 8'h3C};
    base_addr = 8'h00;
    for (int d = 0; d < 8; d++) begin
      for (int fc = 0; fc < 8; fc++) begin
        show(256 + d * 16 + fc * 2, 6);
        rb  = row3[d];
        exp = rb[7 - fc];
        total++;
        if (dr32 !== exp || rgb32 !== (exp ? 8'hFF : 8'h00)) begin
          bad++;
          $display("FAIL w32 d=%0d c=%0d: dr=%b rgb=%h want %b",
                   d, fc, dr32, rgb32, exp);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    resetN = 1'b0;
    sof = 1'b0;
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    base_addr = 8'h10;
    hl_en = 1'b0;
    hl_addr = 8'h00;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'h1111;
      ram32[i] = 32'h0;
    end
    ram[8'h10] = 16'hA3C5;
    ram[8'h19] = 16'hA3C5;
    ram32[0] = 32'h12345678;
    test_reset;
    test_basic_fetch;
    test_addressing;
    test_gap_outside;
    test_highlight;
    test_wrap;
    test_width32;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
